// File: rtl/exec_stage.sv
// exec_stage: execute stage between register-file read and write ports.
// Accepts one decoded instruction per in_valid/in_ready handshake. Ops
// 000-110 are single-cycle ALU ops with a registered one-cycle writeback
// pulse; op 111 is an iterative shift-add multiply taking N cycles.
//
// Optional build macro: EXEC_FORWARD_EN -- when defined, operands are
// bypassed from the pending writeback (wb_*) when the source address
// matches a nonzero wb_addr.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         instruction handshake (in_ready=0 during MUL)
//   in_op, in_rd                opcode, destination register
//   in_rs1, in_rs2              source addresses (forwarding only)
//   in_a, in_b                  operands from register file
//   wb_en, wb_addr, wb_data     register file write port
//   busy                        high while a multiply is iterating
module exec_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [4:0]   in_rd,
  input  logic [4:0]   in_rs1,
  input  logic [4:0]   in_rs2,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         wb_en,
  output logic [4:0]   wb_addr,
  output logic [N-1:0] wb_data,
  output logic         busy
);

  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST_ITER = SW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [0:0]   state;
  logic         accept;
  logic [N-1:0] opA;
  logic [N-1:0] opB;
  logic [N-1:0] aluResult;
  logic signed [N-1:0] sA;
  logic signed [N-1:0] sB;

  logic [N-1:0] mcand;
  logic [N-1:0] mplr;
  logic [N-1:0] acc;
  logic [N-1:0] accNext;
  logic [SW-1:0] cnt;
  logic [4:0]   mulRd;

  assign in_ready = (state == IDLE);
  assign busy     = (state == MUL);
  assign accept   = in_valid & in_ready;

`ifdef EXEC_FORWARD_EN
  // The register file commits wb_data on the same edge that this stage
  // accepts the dependent instruction, so the read value is stale.
  assign opA = (wb_en && (in_rs1 != 5'd0) && (wb_addr == in_rs1)) ? wb_data : in_a;
  assign opB = (wb_en && (in_rs2 != 5'd0) && (wb_addr == in_rs2)) ? wb_data : in_b;
`else
  logic unusedRs;
  assign unusedRs = ^{in_rs1, in_rs2};
  assign opA = in_a;
  assign opB = in_b;
`endif

  assign sA = opA;
  assign sB = opB;

  always_comb begin
    aluResult = '0;
    case (in_op)
      OP_ADD:  aluResult = opA + opB;
      OP_SUB:  aluResult = opA - opB;
      OP_AND:  aluResult = opA & opB;
      OP_OR:   aluResult = opA | opB;
      OP_XOR:  aluResult = opA ^ opB;
      OP_SLL:  aluResult = opA << opB[SW-1:0];
      OP_SLT:  aluResult = {{(N-1){1'b0}}, (sA < sB)};
      default: aluResult = '0;
    endcase
  end

  assign accNext = acc + (mplr[0] ? mcand : '0);

  // Stage boundary: accept / multiply iteration -> registered writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      mulRd   <= '0;
    end else begin
      wb_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_op == OP_MUL) begin
              mcand <= opA;
              mplr  <= opB;
              acc   <= '0;
              cnt   <= '0;
              mulRd <= in_rd;
              state <= MUL;
            end else if (in_rd != 5'd0) begin
              // rd=0 results are discarded so wb_addr/wb_data keep the
              // last real writeback.
              wb_data <= aluResult;
              wb_addr <= in_rd;
              wb_en   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc   <= accNext;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            if (mulRd != 5'd0) begin
              wb_data <= accNext;
              wb_addr <= mulRd;
              wb_en   <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
Execute stage sitting directly downstream of the register file read ports and upstream of its write port. It accepts one decoded instruction per handshake, with operands already read (rdA/rdB values) and their source addresses. It computes single-cycle ALU ops or an iterative shift-add multiply. It drives the register file write port (writeEnable/writeAddr/writeData) with a registered one-cycle writeback pulse.

Parameters:
N, 32, datapath width; matches register file N. Must be a power of two, at least 8.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset; asynchronous, active-low.
in_valid  input  1  instruction valid.
in_ready  output  1  stage can accept; combinational from state (1 in IDLE, 0 in MUL).
in_op  input  3  opcode (see Behaviour).
in_rd  input  5  destination register.
in_rs1  input  5  source A address (used for forwarding only).
in_rs2  input  5  source B address (used for forwarding only).
in_a  input  N  operand A from register file rdA.
in_b  input  N  operand B from register file rdB.
wb_en  output  1  writeback strobe; connects to register file writeEnable.
wb_addr  output  5  connects to writeAddr.
wb_data  output  N  connects to writeData.
busy  output  1  high while in MUL state.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. wb_en=0, wb_addr=0, wb_data=0, busy=0, mul counter=0, internal product/operand registers=0. in_ready=1 once reset is released.
- Accept: an instruction is accepted on a rising edge where in_valid=1 and in_ready=1. in_valid with in_ready=0 is ignored; the upstream holds it.
- Opcodes (all N-bit, wrap-around, no flags):
  - 000 ADD a+b
  - 001 SUB a-b
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL: a << b[log2(N)-1:0]
  - 110 SLT: signed a<b gives 1, else 0, zero-extended
  - 111 MUL: low N bits of a*b
- ALU ops 000-110: result registered on the accept edge. wb_en=1 for exactly the following cycle, with wb_addr=in_rd and wb_data=result. Latency 1; throughput 1 per cycle.
- wb_en is a single-cycle pulse and is deasserted on every edge that does not register a new result. wb_addr and wb_data hold their last values while wb_en=0.
- rd=0: the result is computed but wb_en stays 0. Register 0 is never written by this stage.
- MUL state machine: IDLE -> MUL on accept of op 111. The accept edge captures multiplicand=a, multiplier=b, acc=0, cnt=0, and sets busy=1.
- In MUL, each edge: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt++. The edge performing iteration N (cnt==N-1) registers wb_data=acc final, wb_addr=rd, wb_en=(rd!=0), and moves to IDLE with busy=0.
- MUL timing: accept at edge k gives wb_en visible after edge k+N. in_ready is 0 during cycles k+1..k+N and 1 again in the writeback cycle, so back-to-back acceptance in that cycle is legal.
- No writeback backpressure: the register file always accepts.
- Reset asserted mid-MUL aborts the operation immediately. No writeback is produced, and the stage is in IDLE after release.

Optional Feature:
EXEC_FORWARD_EN. When defined, in IDLE each operand is replaced by wb_data if wb_en=1 and wb_addr equals the operand's source address (in_rs1 for A, in_rs2 for B); in_rs1/in_rs2 of 0 never match. This closes the one-cycle hazard where the register file has not yet committed the previous result. When undefined, in_rs1/in_rs2 are unused, in_a/in_b are used as-is, and upstream must insert a bubble between dependent instructions.

Test Plan:
- Reset: hold rst_n=0 and drive in_valid=1 -> wb_en=0, wb_data=0, busy=0; after release, in_ready=1.
- ALU sweep, N=32, rd=5: ADD 7+9 -> wb_data=16 next cycle. SUB 3-5 -> 0xFFFFFFFE. SLL 1<<31 -> 0x80000000. SLT 0xFFFFFFFF vs 1 -> 1. Each produces a single wb_en pulse with wb_addr=5.
- MUL: a=0x0001_0001, b=0x0000_FFFF, rd=3, accepted at edge k -> in_ready=0 for 32 cycles, wb_en only after edge k+32, wb_data=0xFFFF_FFFF. A new ADD accepted in the writeback cycle -> result one cycle later.
- rd=0: ADD 1+1 with rd=0 -> wb_en stays 0.
- Reset mid-MUL: assert rst_n=0 at iteration 10 -> no wb_en, busy=0. A subsequent ADD works normally.
- Forwarding (EXEC_FORWARD_EN): ADD x4=2+3, then next cycle ADD rd=6, rs1=4 with stale in_a=0 and in_b=1 -> wb_data=6. With the macro undefined -> wb_data=1.
